// File: rtl/mem_cipher_seq_if.sv
// Memory-side bus of the cipher sequencer. The sequencer is the master and drives
// address/write data/write enable; the memory returns registered read data.
interface mem_cipher_seq_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // No handshake on this bus: the write is committed on every rising edge
    // with mem_we=1. Read data is valid one cycle after its address was presented.
    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/mem_cipher_seq.sv
// In-place block cipher sequencer: reads LEN words from BASE, encrypts or decrypts each
// with a latched 16-bit key, and writes it back. Two cycles per word (RD, WR).
module mem_cipher_seq #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int KEY_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [KEY_W-1:0]  key_in,
    mem_cipher_seq_if.master  mem,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_done,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic              mode_r;
    logic [KEY_W-1:0]  key_r;
    logic [DATA_W-1:0] key_full;
    logic [DATA_W-1:0] enc_mix;
    logic [DATA_W-1:0] enc_word;
    logic [DATA_W-1:0] dec_word;
    logic              accept;

    assign accept = (state == IDLE) && start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (length == '0) ? DONE : RD;
                end
            end
            RD:      state_next = WR;
            WR:      state_next = (remaining == CNT_ONE) ? DONE : RD;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command latch and walk counters; ptr wraps naturally at 2**ADDR_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            remaining  <= '0;
            mode_r     <= 1'b0;
            key_r      <= '0;
            words_done <= '0;
        end else if (accept) begin
            ptr        <= base_addr;
            remaining  <= length;
            mode_r     <= mode;
            key_r      <= key_in;
            words_done <= '0;
        end else if (state == WR) begin
            ptr        <= ptr + PTR_ONE;
            remaining  <= remaining - CNT_ONE;
            words_done <= words_done + CNT_ONE;
        end
    end

    // Encrypt is rotl1(x ^ K); decrypt rotr1(x) ^ K undoes it exactly
    assign key_full = {key_r, key_r};
    assign enc_mix  = mem.mem_rdata ^ key_full;
    assign enc_word = {enc_mix[DATA_W-2:0], enc_mix[DATA_W-1]};
    assign dec_word = {mem.mem_rdata[0], mem.mem_rdata[DATA_W-1:1]} ^ key_full;

    // Bus and status outputs decoded from registered state only
    always_comb begin
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        mem.mem_we    = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            RD: begin
                mem.mem_addr = ptr;
                busy         = 1'b1;
            end
            WR: begin
                mem.mem_addr  = ptr;
                mem.mem_wdata = mode_r ? dec_word : enc_word;
                mem.mem_we    = 1'b1;
                busy          = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_dbg = state;

    a_done_single: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
    a_wr_has_work: assert property (@(posedge clk) disable iff (!rst_n)
        (state == WR) |-> (remaining != '0));
    a_start_ignored: assert property (@(posedge clk) disable iff (!rst_n)
        (state != IDLE && start) |=> ($stable(mode_r) && $stable(key_r)));

endmodule

// File: tb/tb_mem_cipher_seq.sv
// Directed bench for mem_cipher_seq: behavioural 1024x32 memory with registered read,
// hand-computed cipher vectors, cycle-accurate done/latency and reset-abort checks.
module tb_mem_cipher_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic [15:0] key_in;
    logic        busy;
    logic        done;
    logic [10:0] words_done;
    logic [1:0]  state_dbg;

    logic [31:0] mem [0:1023];
    logic [31:0] rdata_q;
    logic        poke_en;
    logic [9:0]  poke_addr;
    logic [31:0] poke_data;

    int n_checks = 0;
    int n_pass   = 0;

    int r_done_cyc;
    int r_n_done;
    int r_n_we;
    bit r_busy_seen;

    mem_cipher_seq_if bus ();

    mem_cipher_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .base_addr  (base_addr),
        .length     (length),
        .key_in     (key_in),
        .mem        (bus),
        .busy       (busy),
        .done       (done),
        .words_done (words_done),
        .state_dbg  (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Memory model: registered read, write on mem_we, bench preload port
    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        rdata_q <= mem[bus.mem_addr];
    end
    assign bus.mem_rdata = rdata_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic mem_poke(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // Issue one command; cycle k is the interval after edge k-1 (edge 0 samples start).
    // Start is re-pulsed in cycles g0/g1 to probe that it is ignored outside IDLE.
    task automatic run_cmd(input logic m, input logic [9:0] base, input logic [10:0] len,
                           input logic [15:0] key, input int g0, input int g1);
        r_done_cyc  = -1;
        r_n_done    = 0;
        r_n_we      = 0;
        r_busy_seen = 1'b0;
        @(negedge clk);
        mode      = m;
        base_addr = base;
        length    = len;
        key_in    = key;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        key_in    = ~key;
        mode      = ~m;
        base_addr = base + 10'd100;
        length    = 11'd7;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (done) begin
                r_n_done++;
                if (r_done_cyc < 0) r_done_cyc = k;
            end
            if (bus.mem_we) r_n_we++;
            if (busy) r_busy_seen = 1'b1;
            start = (k == g0) || (k == g1);
            if (r_done_cyc >= 0 && k >= r_done_cyc + 3) break;
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        base_addr = '0;
        length    = '0;
        key_in    = '0;
        poke_en   = 1'b0;
        poke_addr = '0;
        poke_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_words", {21'd0, words_done}, 32'd0);
        check("rst_addr", {22'd0, bus.mem_addr}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        rst_n = 1'b1;

        // 1: encrypt one word
        mem_poke(10'd4, 32'h4444_4444);
        mem_poke(10'd5, 32'h0000_0001);
        mem_poke(10'd6, 32'h6666_6666);
        run_cmd(1'b0, 10'd5, 11'd1, 16'h0032, 0, 0);
        check("enc_word", mem[5], 32'h0064_0066);
        check("enc_done_cyc", r_done_cyc, 32'd3);
        check("enc_n_done", r_n_done, 32'd1);
        check("enc_n_we", r_n_we, 32'd1);
        check("enc_words", {21'd0, words_done}, 32'd1);

        // 2: decrypt restores the plaintext, neighbours untouched
        run_cmd(1'b1, 10'd5, 11'd1, 16'h0032, 0, 0);
        check("dec_word", mem[5], 32'h0000_0001);
        check("dec_m4", mem[4], 32'h4444_4444);
        check("dec_m6", mem[6], 32'h6666_6666);

        // 3: address wrap 1022,1023,0,1 with key 0x1234
        mem_poke(10'd1022, 32'h0000_0000);
        mem_poke(10'd1023, 32'hFFFF_FFFF);
        mem_poke(10'd0,    32'h8000_0000);
        mem_poke(10'd1,    32'h1234_1234);
        mem_poke(10'd2,    32'hA5A5_A5A5);
        run_cmd(1'b0, 10'd1022, 11'd4, 16'h1234, 0, 0);
        check("wrap_1022", mem[1022], 32'h2468_2468);
        check("wrap_1023", mem[1023], 32'hDB97_DB97);
        check("wrap_0", mem[0], 32'h2468_2469);
        check("wrap_1", mem[1], 32'h0000_0000);
        check("wrap_2", mem[2], 32'hA5A5_A5A5);
        check("wrap_done_cyc", r_done_cyc, 32'd9);
        check("wrap_words", {21'd0, words_done}, 32'd4);

        // 4: zero length, start re-pulsed while in DONE
        mem_poke(10'd7, 32'h7777_7777);
        run_cmd(1'b0, 10'd7, 11'd0, 16'h0032, 1, 0);
        check("len0_busy", {31'd0, r_busy_seen}, 32'd0);
        check("len0_done_cyc", r_done_cyc, 32'd1);
        check("len0_n_done", r_n_done, 32'd1);
        check("len0_n_we", r_n_we, 32'd0);
        check("len0_words", {21'd0, words_done}, 32'd0);
        check("len0_mem", mem[7], 32'h7777_7777);

        // 5: start pulsed during WR and RD of a 3-word decrypt
        mem_poke(10'd20, 32'h0064_0066);
        mem_poke(10'd21, 32'h0064_0067);
        mem_poke(10'd22, 32'h0000_0000);
        run_cmd(1'b1, 10'd20, 11'd3, 16'h0032, 2, 5);
        check("busy_n_done", r_n_done, 32'd1);
        check("busy_n_we", r_n_we, 32'd3);
        check("busy_done_cyc", r_done_cyc, 32'd7);
        check("busy_m20", mem[20], 32'h0000_0001);
        check("busy_m21", mem[21], 32'h8000_0001);
        check("busy_m22", mem[22], 32'h0032_0032);

        // 6: reset during RD of the second word
        mem_poke(10'd10, 32'h0000_0001);
        mem_poke(10'd11, 32'h1111_1111);
        mem_poke(10'd12, 32'h2222_2222);
        @(negedge clk);
        mode      = 1'b0;
        base_addr = 10'd10;
        length    = 11'd3;
        key_in    = 16'h0032;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_pre_state", {30'd0, state_dbg}, 32'd1);
        check("abort_pre_addr", {22'd0, bus.mem_addr}, 32'd11);
        rst_n = 1'b0;
        #1;
        check("abort_we", {31'd0, bus.mem_we}, 32'd0);
        check("abort_state", {30'd0, state_dbg}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        r_n_done = 0;
        r_n_we   = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (done) r_n_done++;
            if (bus.mem_we) r_n_we++;
        end
        check("abort_n_done", r_n_done, 32'd0);
        check("abort_n_we", r_n_we, 32'd0);
        check("abort_m10", mem[10], 32'h0064_0066);
        check("abort_m11", mem[11], 32'h1111_1111);
        check("abort_m12", mem[12], 32'h2222_2222);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
